// File: rtl/control_buscaminas.sv
// Minesweeper game controller: board generation handshake, cursor, reveal/flag masks
// and win/lose decision for a DIM x DIM board.
module control_buscaminas #(
    parameter int unsigned DIM     = 8,
    parameter int unsigned AW      = $clog2(DIM),
    parameter int unsigned MINAS_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inicio,
    input  logic [MINAS_W-1:0]   num_minas,
    input  logic                 btn_arriba,
    input  logic                 btn_abajo,
    input  logic                 btn_izq,
    input  logic                 btn_der,
    input  logic                 btn_revelar,
    input  logic                 btn_bandera,
    output logic                 gen_start,
    input  logic                 gen_done,
    output logic [2*AW-1:0]      cell_addr,
    input  logic                 cell_mina,
    input  logic [3:0]           cell_cuenta,
    output logic [AW-1:0]        cursor_fila,
    output logic [AW-1:0]        cursor_col,
    output logic [DIM*DIM-1:0]   revelada,
    output logic [DIM*DIM-1:0]   bandera,
    output logic [3:0]           ult_cuenta,
    output logic [2:0]           estado,
    output logic                 gano,
    output logic                 perdio
);

    localparam int unsigned CELLS = DIM * DIM;
    localparam int unsigned CW    = $clog2(CELLS) + 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StGen  = 3'd1,
        StPlay = 3'd2,
        StRead = 3'd3,
        StEval = 3'd4,
        StWin  = 3'd5,
        StLose = 3'd6
    } estado_e;

    estado_e              r_estado, w_estado;
    logic [AW-1:0]        r_fila, w_fila;
    logic [AW-1:0]        r_col, w_col;
    logic [CELLS-1:0]     r_rev, w_rev;
    logic [CELLS-1:0]     r_flag, w_flag;
    logic [3:0]           r_ult, w_ult;
    logic                 r_gen_start, w_gen_start;
    logic [2*AW-1:0]      r_addr, w_addr;
    logic                 r_gano, w_gano;
    logic                 r_perdio, w_perdio;
    logic [CW-1:0]        r_cont, w_cont;
    logic [MINAS_W-1:0]   r_minas, w_minas;

    logic [2*AW-1:0]      w_idx;
    logic [CW-1:0]        w_cont_inc;
    logic [31:0]          w_minas_lim;
    logic [31:0]          w_objetivo;

    // With DIM a power of two, {fila,col} equals fila*DIM+col.
    assign w_idx      = {r_fila, r_col};
    assign w_cont_inc = r_cont + CW'(1);

    // Safe-cell target; a full board of mines is clamped to leave one safe cell.
    always_comb begin
        w_minas_lim = 32'(r_minas);
        if (w_minas_lim >= CELLS) begin
            w_minas_lim = CELLS - 1;
        end
        w_objetivo = CELLS - w_minas_lim;
    end

    always_comb begin
        w_estado    = r_estado;
        w_fila      = r_fila;
        w_col       = r_col;
        w_rev       = r_rev;
        w_flag      = r_flag;
        w_ult       = r_ult;
        w_gen_start = 1'b0;
        w_addr      = r_addr;
        w_cont      = r_cont;
        w_minas     = r_minas;

        if (inicio && (r_estado != StGen)) begin
            w_estado    = StGen;
            w_gen_start = 1'b1;
            w_fila      = '0;
            w_col       = '0;
            w_rev       = '0;
            w_flag      = '0;
            w_ult       = '0;
            w_cont      = '0;
            w_minas     = num_minas;
        end else begin
            case (r_estado)
                StGen: begin
                    if (gen_done) begin
                        w_estado = StPlay;
                    end
                end
                StPlay: begin
                    // A no-op reveal still consumes the cycle's single action.
                    if (btn_revelar) begin
                        if (!r_rev[w_idx] && !r_flag[w_idx]) begin
                            w_addr   = w_idx;
                            w_estado = StRead;
                        end
                    end else if (btn_bandera) begin
                        if (!r_rev[w_idx]) begin
                            w_flag[w_idx] = ~r_flag[w_idx];
                        end
                    end else if (btn_arriba) begin
                        w_fila = r_fila - AW'(1);
                    end else if (btn_abajo) begin
                        w_fila = r_fila + AW'(1);
                    end else if (btn_izq) begin
                        w_col = r_col - AW'(1);
                    end else if (btn_der) begin
                        w_col = r_col + AW'(1);
                    end
                end
                StRead: begin
                    w_estado = StEval;
                end
                StEval: begin
                    w_rev[r_addr] = 1'b1;
                    if (cell_mina) begin
                        w_estado = StLose;
                    end else begin
                        w_ult    = cell_cuenta;
                        w_cont   = w_cont_inc;
                        w_estado = (32'(w_cont_inc) == w_objetivo) ? StWin : StPlay;
                    end
                end
                default: ;
            endcase
        end

        w_gano   = (w_estado == StWin);
        w_perdio = (w_estado == StLose);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= StIdle;
            r_fila      <= '0;
            r_col       <= '0;
            r_rev       <= '0;
            r_flag      <= '0;
            r_ult       <= '0;
            r_gen_start <= 1'b0;
            r_addr      <= '0;
            r_gano      <= 1'b0;
            r_perdio    <= 1'b0;
            r_cont      <= '0;
            r_minas     <= '0;
        end else begin
            r_estado    <= w_estado;
            r_fila      <= w_fila;
            r_col       <= w_col;
            r_rev       <= w_rev;
            r_flag      <= w_flag;
            r_ult       <= w_ult;
            r_gen_start <= w_gen_start;
            r_addr      <= w_addr;
            r_gano      <= w_gano;
            r_perdio    <= w_perdio;
            r_cont      <= w_cont;
            r_minas     <= w_minas;
        end
    end

    assign gen_start   = r_gen_start;
    assign cell_addr   = r_addr;
    assign cursor_fila = r_fila;
    assign cursor_col  = r_col;
    assign revelada    = r_rev;
    assign bandera     = r_flag;
    assign ult_cuenta  = r_ult;
    assign estado      = r_estado;
    assign gano        = r_gano;
    assign perdio      = r_perdio;

endmodule

// File: tb/tb_control_buscaminas.sv
// Bench for control_buscaminas: directed scenarios plus randomized play against a
// cell-level game model, with a 1-cycle-latency board datapath stand-in.
`timescale 1ns/1ps
module tb_control_buscaminas;

    localparam int DIM   = 8;
    localparam int CELLS = DIM * DIM;

    localparam logic [6:0] KArr = 7'h01;
    localparam logic [6:0] KAba = 7'h02;
    localparam logic [6:0] KIzq = 7'h04;
    localparam logic [6:0] KDer = 7'h08;
    localparam logic [6:0] KRev = 7'h10;
    localparam logic [6:0] KBan = 7'h20;
    localparam logic [6:0] KIni = 7'h40;

    logic        clk = 1'b0;
    logic        rst;
    logic        inicio;
    logic [3:0]  num_minas;
    logic        btn_arriba, btn_abajo, btn_izq, btn_der, btn_revelar, btn_bandera;
    logic        gen_start;
    logic        gen_done;
    logic [5:0]  cell_addr;
    logic        cell_mina;
    logic [3:0]  cell_cuenta;
    logic [2:0]  cursor_fila, cursor_col;
    logic [63:0] revelada, bandera;
    logic [3:0]  ult_cuenta;
    logic [2:0]  estado;
    logic        gano, perdio;

    always #5 clk = ~clk;

    control_buscaminas #(.DIM(8), .AW(3), .MINAS_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .inicio      (inicio),
        .num_minas   (num_minas),
        .btn_arriba  (btn_arriba),
        .btn_abajo   (btn_abajo),
        .btn_izq     (btn_izq),
        .btn_der     (btn_der),
        .btn_revelar (btn_revelar),
        .btn_bandera (btn_bandera),
        .gen_start   (gen_start),
        .gen_done    (gen_done),
        .cell_addr   (cell_addr),
        .cell_mina   (cell_mina),
        .cell_cuenta (cell_cuenta),
        .cursor_fila (cursor_fila),
        .cursor_col  (cursor_col),
        .revelada    (revelada),
        .bandera     (bandera),
        .ult_cuenta  (ult_cuenta),
        .estado      (estado),
        .gano        (gano),
        .perdio      (perdio)
    );

    // Board contents seen by the datapath stand-in.
    bit         mapa_mina   [CELLS];
    logic [3:0] mapa_cuenta [CELLS];

    always @(posedge clk) begin
        cell_mina   <= mapa_mina[cell_addr];
        cell_cuenta <= mapa_cuenta[cell_addr];
    end

    // Game model: state number, cursor, per-cell masks and revealed-safe counter.
    int          m_st, m_f, m_c, m_cnt, m_minas, m_addr;
    logic [63:0] m_rev, m_flag;
    logic [3:0]  m_ult;
    bit          m_gs;

    int total;
    int bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_st = 0; m_f = 0; m_c = 0; m_cnt = 0; m_minas = 0; m_addr = 0;
        m_rev = '0; m_flag = '0; m_ult = '0; m_gs = 1'b0;
    endtask

    task automatic modelo_paso();
        int idx;
        int lim;
        m_gs = 1'b0;
        if (rst) begin
            modelo_reset();
            return;
        end
        idx = m_f * DIM + m_c;
        if (inicio && m_st != 1) begin
            m_st = 1; m_gs = 1'b1; m_f = 0; m_c = 0; m_cnt = 0;
            m_rev = '0; m_flag = '0; m_ult = '0; m_minas = int'(num_minas);
        end else begin
            case (m_st)
                1: if (gen_done) m_st = 2;
                2: begin
                    if (btn_revelar) begin
                        if (!m_rev[idx] && !m_flag[idx]) begin
                            m_addr = idx;
                            m_st   = 3;
                        end
                    end else if (btn_bandera) begin
                        if (!m_rev[idx]) m_flag[idx] = ~m_flag[idx];
                    end else if (btn_arriba) m_f = (m_f + DIM - 1) % DIM;
                    else if (btn_abajo)      m_f = (m_f + 1) % DIM;
                    else if (btn_izq)        m_c = (m_c + DIM - 1) % DIM;
                    else if (btn_der)        m_c = (m_c + 1) % DIM;
                end
                3: m_st = 4;
                4: begin
                    m_rev[m_addr] = 1'b1;
                    if (mapa_mina[m_addr]) begin
                        m_st = 6;
                    end else begin
                        m_ult = mapa_cuenta[m_addr];
                        m_cnt++;
                        lim  = (m_minas > CELLS - 1) ? CELLS - 1 : m_minas;
                        m_st = (m_cnt == CELLS - lim) ? 5 : 2;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic comprobar();
        chk("estado",     64'(estado),                   64'(m_st));
        chk("cursor",     64'({cursor_fila, cursor_col}), 64'(m_f * DIM + m_c));
        chk("gen_start",  64'(gen_start),                64'(m_gs));
        chk("revelada",   revelada,                      m_rev);
        chk("bandera",    bandera,                       m_flag);
        chk("ult_cuenta", 64'(ult_cuenta),               64'(m_ult));
        chk("cell_addr",  64'(cell_addr),                64'(m_addr));
        chk("gano",       64'(gano),                     64'(m_st == 5));
        chk("perdio",     64'(perdio),                   64'(m_st == 6));
    endtask

    task automatic ciclo();
        @(posedge clk);
        modelo_paso();
        #1;
        comprobar();
    endtask

    task automatic pulsa(input logic [6:0] m);
        {inicio, btn_bandera, btn_revelar, btn_der, btn_izq, btn_abajo, btn_arriba} = m;
        ciclo();
        {inicio, btn_bandera, btn_revelar, btn_der, btn_izq, btn_abajo, btn_arriba} = '0;
    endtask

    task automatic limpia_mapa();
        for (int i = 0; i < CELLS; i++) begin
            mapa_mina[i]   = 1'b0;
            mapa_cuenta[i] = 4'($urandom_range(0, 8));
        end
    endtask

    task automatic mapa_aleatorio(input int nm);
        int puestos;
        int p;
        limpia_mapa();
        puestos = 0;
        while (puestos < nm) begin
            p = int'($urandom_range(0, CELLS - 1));
            if (!mapa_mina[p]) begin
                mapa_mina[p] = 1'b1;
                puestos++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        {inicio, btn_bandera, btn_revelar, btn_der, btn_izq, btn_abajo, btn_arriba} = '0;
        num_minas = '0;
        gen_done  = 1'b0;
        limpia_mapa();
        modelo_reset();
        ciclo();
        ciclo();
        rst = 1'b0;

        // Board with one mine at (4,4); (1,1) is safe with count 2.
        limpia_mapa();
        mapa_mina[36]  = 1'b1;
        mapa_cuenta[9] = 4'd2;
        num_minas = 4'd3;
        pulsa(KIni);
        repeat (4) ciclo();
        gen_done = 1'b1;
        ciclo();
        gen_done = 1'b0;

        pulsa(KArr);
        pulsa(KIzq);
        chk("cursor_wrap77", 64'({cursor_fila, cursor_col}), 64'd63);
        pulsa(KDer);
        pulsa(KAba | KDer);
        chk("cursor_prio00", 64'({cursor_fila, cursor_col}), 64'd0);

        pulsa(KAba); pulsa(KAba); pulsa(KDer); pulsa(KDer); pulsa(KDer);
        pulsa(KBan);
        chk("flag_bit19", 64'(bandera[19]), 64'd1);
        pulsa(KRev);
        pulsa(KBan);

        pulsa(KArr); pulsa(KIzq); pulsa(KIzq);
        pulsa(KRev);
        ciclo();
        ciclo();
        chk("ult_cuenta_2", 64'(ult_cuenta), 64'd2);

        pulsa(KAba); pulsa(KAba); pulsa(KAba); pulsa(KDer); pulsa(KDer); pulsa(KDer);
        pulsa(KRev);
        ciclo();
        ciclo();
        pulsa(KRev); pulsa(KBan); pulsa(KArr); pulsa(KDer);
        chk("perdio_hold", 64'(perdio), 64'd1);

        // Asynchronous reset while the read is outstanding.
        pulsa(KIni);
        gen_done = 1'b1;
        ciclo();
        gen_done = 1'b0;
        pulsa(KRev);
        #2;
        rst = 1'b1;
        #1;
        modelo_reset();
        comprobar();
        ciclo();
        rst = 1'b0;

        // One mine at (5,6): reveal all 63 safe cells in raster order.
        limpia_mapa();
        mapa_mina[46] = 1'b1;
        num_minas = 4'd1;
        pulsa(KIni);
        gen_done = 1'b1;
        ciclo();
        gen_done = 1'b0;
        for (int f = 0; f < DIM; f++) begin
            for (int c = 0; c < DIM; c++) begin
                if (f * DIM + c != 46) begin
                    pulsa(KRev);
                    ciclo();
                    ciclo();
                end
                pulsa(KDer);
            end
            pulsa(KAba);
        end
        chk("gano_63", 64'(gano), 64'd1);
        pulsa(KIni);
        chk("rev_cleared", revelada, 64'd0);

        // Randomized play with fresh boards on each restart.
        for (int n = 0; n < 3000; n++) begin
            inicio      = ($urandom_range(0, 59) == 0);
            btn_revelar = ($urandom_range(0, 2) == 0);
            btn_bandera = ($urandom_range(0, 3) == 0);
            btn_arriba  = ($urandom_range(0, 3) == 0);
            btn_abajo   = ($urandom_range(0, 3) == 0);
            btn_izq     = ($urandom_range(0, 3) == 0);
            btn_der     = ($urandom_range(0, 3) == 0);
            gen_done    = ($urandom_range(0, 2) == 0);
            if (inicio) begin
                num_minas = 4'($urandom_range(0, 15));
                mapa_aleatorio(int'(num_minas));
            end
            ciclo();
            {inicio, btn_bandera, btn_revelar, btn_der, btn_izq, btn_abajo, btn_arriba} = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
